// File: rtl/encoder_framer.sv
// Framed rate-1/2, K=3 convolutional encoder (g0=7, g1=5) with a one-entry
// output register, two-symbol zero tail and a last-symbol marker.
module encoder_framer #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [1:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       code_last,
    output logic       busy,
    output logic [1:0] dbg_state_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    // Handshake: a symbol moves when valid and ready are both high on a
    // rising edge; the single output slot may refill on the edge it drains.
    logic [1:0]       state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tail_q, tail_d;
    logic [1:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic slot_free;
    logic load;
    logic u;
    logic mark_last;

    assign slot_free   = !valid_q || code_ready;
    assign bit_ready   = (state_q == ST_ENCODE) && slot_free;
    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign code_last   = last_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        tail_d    = tail_q;
        code_d    = code_q;
        valid_d   = valid_q;
        last_d    = last_q;
        load      = 1'b0;
        u         = 1'b0;
        mark_last = 1'b0;

        if (code_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ENCODE;
                    s_d     = 2'b00;
                    cnt_d   = '0;
                    tail_d  = 1'b0;
                end
            end
            ST_ENCODE: begin
                if (bit_valid && slot_free) begin
                    load  = 1'b1;
                    u     = bit_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_FLUSH;
                        tail_d  = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (tail_q) begin
                        mark_last = 1'b1;
                        state_d   = ST_IDLE;
                        tail_d    = 1'b0;
                    end else begin
                        tail_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // code_out is {c0, c1}; the shift register keeps the newest bit in s[1].
        if (load) begin
            code_d  = {u ^ s_q[1] ^ s_q[0], u ^ s_q[0]};
            valid_d = 1'b1;
            last_d  = mark_last;
            s_d     = {u, s_q[1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 2'b00;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

endmodule
